// File: rtl/packet_generator.sv
// Transmit end of the framed-sequence packet link: emits bursts of
// {frame code, payload, sequence} packets with optional error injection.
module packet_generator #(
    parameter int BUS_SIZE  = 16,
    parameter int WORD_SIZE = 4,
    parameter int PAY_SIZE  = BUS_SIZE - 2*WORD_SIZE
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [7:0]          burst_len,
    input  logic [PAY_SIZE-1:0] payload,
    input  logic                inject_frame_err,
    input  logic                inject_seq_err,
    output logic [BUS_SIZE-1:0] data_bus,
    output logic                valid,
    output logic                busy,
    output logic                done,
    output logic [15:0]         pkt_count,
    output logic [7:0]          err_count
);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_DONE} state_e;

    localparam logic [WORD_SIZE-1:0] SEQ_INIT = WORD_SIZE'(1);

    state_e                state_q, state_d;
    logic [7:0]            remaining_q, remaining_d;
    logic [WORD_SIZE-1:0]  seq_q, seq_d;
    logic                  pend_f_q, pend_f_d;
    logic                  pend_s_q, pend_s_d;
    logic [BUS_SIZE-1:0]   data_q, data_d;
    logic                  valid_q, valid_d;
    logic [15:0]           pkt_count_q, pkt_count_d;
    logic [7:0]            err_count_q, err_count_d;

    logic                  launch;
    logic                  consume_f;
    logic                  consume_s;
    logic [WORD_SIZE-1:0]  frame_field;
    logic [WORD_SIZE-1:0]  seq_field;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        state_d     = state_q;
        remaining_d = remaining_q;
        launch      = 1'b0;

        // remaining counts packets still to launch after the current one.
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (burst_len != 8'd0) begin
                        state_d     = S_SEND;
                        launch      = 1'b1;
                        remaining_d = burst_len - 8'd1;
                    end else begin
                        state_d     = S_DONE;
                        remaining_d = 8'd0;
                    end
                end
            end
            S_SEND: begin
                if (remaining_q != 8'd0) begin
                    launch      = 1'b1;
                    remaining_d = remaining_q - 8'd1;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        consume_f   = launch & pend_f_q;
        consume_s   = launch & pend_s_q & ~pend_f_q;
        frame_field = pend_f_q ? '0 : '1;
        seq_field   = consume_s ? seq_q + 1'b1 : seq_q;

        data_d      = '0;
        valid_d     = launch;
        seq_d       = seq_q;
        pkt_count_d = pkt_count_q;
        err_count_d = err_count_q;

        if (launch) begin
            data_d      = {frame_field, payload, seq_field};
            pkt_count_d = pkt_count_q + 16'd1;
            if (consume_f || consume_s) begin
                seq_d = '0;
                if (err_count_q != 8'hFF) begin
                    err_count_d = err_count_q + 8'd1;
                end
            end else begin
                seq_d = seq_q + 1'b1;
            end
        end

        // A request arriving on the consuming edge re-arms the flag.
        pend_f_d = (pend_f_q & ~consume_f) | inject_frame_err;
        pend_s_d = (pend_s_q & ~consume_s) | inject_seq_err;
    end

    always_ff @(posedge clk) begin
        // NOTE: state flops use non-blocking assignments so all updates see pre-edge values.
        if (reset) begin
            state_q     <= S_IDLE;
            remaining_q <= 8'd0;
            seq_q       <= SEQ_INIT;
            pend_f_q    <= 1'b0;
            pend_s_q    <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            pkt_count_q <= 16'd0;
            err_count_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            seq_q       <= seq_d;
            pend_f_q    <= pend_f_d;
            pend_s_q    <= pend_s_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            pkt_count_q <= pkt_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign data_bus  = data_q;
    assign valid     = valid_q;
    assign busy      = (state_q == S_SEND);
    assign done      = (state_q == S_DONE);
    assign pkt_count = pkt_count_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_packet_generator.sv
// Self-checking bench for packet_generator: a cycle-schedule reference model
// compared every cycle, plus directed bursts with hand-computed packets.
module tb_packet_generator;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  burst_len;
    logic [7:0]  payload;
    logic        inject_frame_err;
    logic        inject_seq_err;
    logic [15:0] data_bus;
    logic        valid;
    logic        busy;
    logic        done;
    logic [15:0] pkt_count;
    logic [7:0]  err_count;

    int n_cmp = 0;
    int n_err = 0;

    packet_generator dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .burst_len        (burst_len),
        .payload          (payload),
        .inject_frame_err (inject_frame_err),
        .inject_seq_err   (inject_seq_err),
        .data_bus         (data_bus),
        .valid            (valid),
        .busy             (busy),
        .done             (done),
        .pkt_count        (pkt_count),
        .err_count        (err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a burst accepted in cycle c occupies cycles c+1..c+L
    // with packets, c+L+1 with done, and the block is idle again from c+L+2.
    int          cyc       = 0;
    int          idle_from = 0;
    int          first_pkt = 1;
    int          last_pkt  = 0;
    int          done_cyc  = -1;
    int          m_seq     = 1;
    bit          m_pf      = 1'b0;
    bit          m_ps      = 1'b0;
    int          m_pkt     = 0;
    int          m_err     = 0;
    bit          chk_en    = 1'b0;
    logic [15:0] exp_data  = '0;
    logic        exp_valid = 1'b0;
    logic        exp_done  = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("model data_bus",  32'(data_bus),  32'(exp_data));
            check("model valid",     32'(valid),     32'(exp_valid));
            check("model busy",      32'(busy),      32'(exp_valid));
            check("model done",      32'(done),      32'(exp_done));
            check("model pkt_count", 32'(pkt_count), 32'(m_pkt));
            check("model err_count", 32'(err_count), 32'(m_err));
        end
        exp_data = '0;
        if (reset) begin
            m_seq     = 1;
            m_pf      = 1'b0;
            m_ps      = 1'b0;
            m_pkt     = 0;
            m_err     = 0;
            idle_from = cyc + 1;
            first_pkt = 1;
            last_pkt  = 0;
            done_cyc  = -1;
            chk_en    = 1'b1;
        end else begin
            if (cyc >= idle_from && start === 1'b1) begin
                first_pkt = cyc + 1;
                last_pkt  = cyc + int'(burst_len);
                done_cyc  = cyc + int'(burst_len) + 1;
                idle_from = cyc + int'(burst_len) + 2;
            end
            if (cyc + 1 >= first_pkt && cyc + 1 <= last_pkt) begin
                if (m_pf) begin
                    exp_data = {4'h0, payload, 4'(m_seq)};
                    m_seq = 0;
                    m_pf  = 1'b0;
                    if (m_err < 255) m_err++;
                end else if (m_ps) begin
                    exp_data = {4'hF, payload, 4'((m_seq + 1) % 16)};
                    m_seq = 0;
                    m_ps  = 1'b0;
                    if (m_err < 255) m_err++;
                end else begin
                    exp_data = {4'hF, payload, 4'(m_seq)};
                    m_seq = (m_seq + 1) % 16;
                end
                m_pkt = (m_pkt + 1) % 65536;
            end
            m_pf = m_pf | inject_frame_err;
            m_ps = m_ps | inject_seq_err;
        end
        exp_valid = (cyc + 1 >= first_pkt && cyc + 1 <= last_pkt);
        exp_done  = (cyc + 1 == done_cyc);
        cyc++;
    end

    // Directed stimulus; inputs change 1 time unit after the rising edge.
    logic [15:0] pkts[$];
    bit          saw_done;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Fixed-length window: cycles N+1 .. N+L+1, ending in cycle N+L+2.
    task automatic run_burst(input int len, input logic [7:0] pay);
        start     = 1'b1;
        burst_len = 8'(len);
        payload   = pay;
        tick();
        start = 1'b0;
        pkts.delete();
        saw_done = 1'b0;
        for (int i = 0; i < len + 1; i++) begin
            if (valid) pkts.push_back(data_bus);
            if (done) saw_done = 1'b1;
            tick();
        end
        check("burst packet count", 32'(pkts.size()), 32'(len));
        check("burst done seen",    32'(saw_done),    32'd1);
    endtask

    task automatic check_pkts(input string name, input logic [15:0] exp[]);
        for (int i = 0; i < exp.size(); i++) begin
            if (i < pkts.size()) check(name, 32'(pkts[i]), 32'(exp[i]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] exp_f[];
        logic [15:0] exp_s[];
        logic [15:0] exp_b[];
        int          nv;

        reset = 1'b1; start = 1'b0; burst_len = '0; payload = '0;
        inject_frame_err = 1'b0; inject_seq_err = 1'b0;
        repeat (3) tick();
        check("reset data_bus",  32'(data_bus),  32'd0);
        check("reset valid",     32'(valid),     32'd0);
        check("reset pkt_count", 32'(pkt_count), 32'd0);
        reset = 1'b0;
        tick();

        // Single packet
        start = 1'b1; burst_len = 8'd1; payload = 8'hA5;
        tick();
        start = 1'b0;
        check("single data_bus", 32'(data_bus), 32'h0000_FA51);
        check("single valid",    32'(valid),    32'd1);
        tick();
        check("single done",      32'(done),      32'd1);
        check("single pkt_count", 32'(pkt_count), 32'd1);
        tick();

        // Sequence wrap over 17 packets from a fresh seq of 1
        reset = 1'b1; tick(); reset = 1'b0; tick();
        run_burst(17, 8'h00);
        for (int i = 0; i < 17 && i < pkts.size(); i++)
            check("wrap seq field", 32'(pkts[i][3:0]), 32'((i + 1) % 16));
        check("wrap err_count", 32'(err_count), 32'd0);

        // Framing injection landing on the packet with seq 5
        reset = 1'b1; tick(); reset = 1'b0; tick();
        fork
            run_burst(8, 8'h3C);
            begin
                repeat (3) tick();
                inject_frame_err = 1'b1;
                tick();
                inject_frame_err = 1'b0;
            end
        join
        exp_f = '{16'hF3C1, 16'hF3C2, 16'hF3C3, 16'hF3C4,
                  16'h03C5, 16'hF3C0, 16'hF3C1, 16'hF3C2};
        check_pkts("frame inject packet", exp_f);
        check("frame inject err_count", 32'(err_count), 32'd1);

        // Sequence injection raised while idle, seq is 3
        inject_seq_err = 1'b1; tick(); inject_seq_err = 1'b0;
        run_burst(4, 8'h11);
        exp_s = '{16'hF114, 16'hF110, 16'hF111, 16'hF112};
        check_pkts("seq inject packet", exp_s);
        check("seq inject err_count", 32'(err_count), 32'd2);

        // Both injects together: frame error wins, seq error follows
        inject_frame_err = 1'b1; inject_seq_err = 1'b1; tick();
        inject_frame_err = 1'b0; inject_seq_err = 1'b0;
        run_burst(4, 8'h22);
        exp_b = '{16'h0223, 16'hF221, 16'hF220, 16'hF221};
        check_pkts("both inject packet", exp_b);
        check("both inject err_count", 32'(err_count), 32'd4);

        // Zero-length burst
        start = 1'b1; burst_len = 8'd0; tick(); start = 1'b0;
        check("zero len done",  32'(done),  32'd1);
        check("zero len valid", 32'(valid), 32'd0);
        tick();
        check("zero len done after", 32'(done), 32'd0);

        // start held high: burst_len must not be resampled mid-burst
        start = 1'b1; burst_len = 8'd4; payload = 8'h77; tick();
        burst_len = 8'd7;
        nv = 0;
        for (int i = 0; i < 4; i++) begin
            if (valid) nv++;
            tick();
        end
        check("held start packets", 32'(nv),   32'd4);
        check("held start done",    32'(done), 32'd1);
        tick();
        check("held start idle valid", 32'(valid), 32'd0);
        check("held start idle busy",  32'(busy),  32'd0);
        tick();
        check("held start restart valid", 32'(valid), 32'd1);
        start = 1'b0;
        repeat (9) tick();

        // Reset during the third packet of ten
        start = 1'b1; burst_len = 8'd10; payload = 8'h99; tick();
        start = 1'b0; tick(); tick();
        reset = 1'b1; tick();
        check("mid reset data_bus",  32'(data_bus),  32'd0);
        check("mid reset valid",     32'(valid),     32'd0);
        check("mid reset busy",      32'(busy),      32'd0);
        check("mid reset done",      32'(done),      32'd0);
        check("mid reset pkt_count", 32'(pkt_count), 32'd0);
        check("mid reset err_count", 32'(err_count), 32'd0);
        reset = 1'b0;
        run_burst(1, 8'h5A);
        if (pkts.size() > 0) check("post reset packet", 32'(pkts[0]), 32'h0000_F5A1);

        // err_count saturation with framing errors on every packet
        inject_frame_err = 1'b1; tick();
        run_burst(200, 8'h01);
        run_burst(200, 8'h01);
        inject_frame_err = 1'b0;
        check("saturated err_count", 32'(err_count), 32'd255);
        check("total pkt_count",     32'(pkt_count), 32'd401);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/packet_generator.md
# packet_generator

Transmit end of the framed-sequence packet link. On a start request it emits a burst of packets on `data_bus`, one per cycle. Each packet carries the all-ones frame code in the top word, a payload in the middle, and a wrapping sequence number in the bottom word. Optional framing and sequence errors can be injected, so the downstream sequence checker can be exercised in-system.

## Interface
- `BUS_SIZE`, 16, packet width in bits.
- `WORD_SIZE`, 4, width of the frame-code and sequence fields.
- `PAY_SIZE`, `BUS_SIZE-2*WORD_SIZE`, payload width (derived; must be ≥1).
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  begin a burst; sampled only in IDLE.
- `burst_len`  in  8  number of packets in the burst; sampled with `start`.
- `payload`  in  PAY_SIZE  payload for the packet launched at the next edge.
- `inject_frame_err`  in  1  request a framing-error packet.
- `inject_seq_err`  in  1  request a sequence-error packet.
- `data_bus`  out  BUS_SIZE  registered packet.
- `valid`  out  1  `data_bus` holds a packet this cycle.
- `busy`  out  1  state is SEND.
- `done`  out  1  one-cycle pulse at end of burst.
- `pkt_count`  out  16  total packets emitted; wraps modulo 2^16.
- `err_count`  out  8  error packets emitted; saturates at 255.

## Operation
- **Packet layout:**
  - `[BUS_SIZE-1 -: WORD_SIZE]` is the frame code, all ones.
  - `[WORD_SIZE +: PAY_SIZE]` is the payload.
  - `[WORD_SIZE-1:0]` is the sequence number.
- **States:** IDLE, SEND, DONE.
  - IDLE: when `start`=1, load `remaining` ← `burst_len`.
    - `burst_len`≠0 → SEND.
    - `burst_len`=0 → DONE; no packet is emitted.
  - SEND: one packet per cycle, and `remaining` decrements. On launching the last packet → DONE.
  - DONE: `done`=1 for one cycle → IDLE.
- **Sequence register `seq` (WORD_SIZE bits):**
  - Reset value 1, matching the checker's first expected value.
  - After each good packet, `seq` ← `seq+1` mod 2^WORD_SIZE (15→0 wraps with no error).
  - `seq` persists across bursts.
- **Injection:**
  - `inject_*` high on any edge sets the matching pending flag.
  - A pending flag is consumed by the next packet launched in SEND.
  - If a flag is re-asserted on the same edge it is consumed, it stays set.
- **Framing-error packet** (`pend_f` set; has priority):
  - Frame field all zeros; payload normal; sequence field = `seq`.
  - Then `seq` ← 0, clear `pend_f`. `pend_s`, if set, remains for a later packet.
- **Sequence-error packet** (`pend_s` set, `pend_f` clear):
  - Sequence field = `seq+1` mod 2^WORD_SIZE; frame code normal.
  - Then `seq` ← 0, clear `pend_s`.
- **Error-packet bookkeeping:**
  - Error packets count toward `burst_len` and `pkt_count`.
  - `err_count` increments per error packet, saturating at 255.
  - The restart at 0 matches checker resynchronisation after F_ERR/SEQ_ERR.
- **Outside SEND:** `valid`=0 and `data_bus`=0. The downstream checker is gated by `valid`.

## Timing
- **Reset** (any state, including mid-burst), values at the next edge:
  - State IDLE; `data_bus`=0, `valid`=0, `busy`=0, `done`=0.
  - `pkt_count`=0, `err_count`=0, `remaining`=0.
  - `seq`=1; pending flags cleared.
  - Any burst in progress is dropped.
- **Burst timing:** `start` high in IDLE during cycle N:
  - Packets appear in cycles N+1 … N+L (L=`burst_len`), back-to-back with `valid`=1.
  - `done`=1 in cycle N+L+1; IDLE from N+L+2.
  - `start` is accepted again in cycle N+L+2.
- **Zero-length burst:** `burst_len`=0 → `done` in cycle N+1; `valid` never rises.
- **`start` outside IDLE:** ignored; `burst_len` is not resampled.
- **`payload` sampling:** sampled on the same edge its packet is registered. Packet in cycle k uses `payload` from cycle k-1.
- **Injection latency:** inject high in cycle k → earliest affected packet is in cycle k+2.
  - Pending flags survive IDLE/DONE.
  - They apply to the first packet of the next burst.
- **Counters:** update on the same edge the packet is registered, so they are visible alongside that packet.

## Test plan
Defaults throughout (16/4/8).
- **Reset then single packet:** `start`=1, `burst_len`=1, payload 0xA5 → cycle N+1 `data_bus`=0xFA51, `valid`=1; cycle N+2 `done`=1; `pkt_count`=1.
- **Wrap:** burst of 17, payload 0x00 → sequence fields 1,2,…,15,0,1; `err_count`=0; checker model reports no error.
- **Framing injection:** mid-burst pulse `inject_frame_err` while `seq`=5 → one packet 0x0xx5; following packets carry seq 0,1,2; `err_count`=1.
- **Sequence injection and priority:**
  - `inject_seq_err` at `seq`=3 → packet sequence field 4, then 0,1….
  - Both injects on the same cycle → frame-error packet, then seq-error packet (sequence field 1), then 0; `err_count`=2.
- **Boundary:**
  - `burst_len`=0 → `done` next cycle, no `valid`.
  - `start` held high through a 4-packet burst → exactly 4 packets, then a new burst starts only after DONE.
- **Reset mid-burst:** reset in 3rd packet of 10 → next cycle all outputs 0, IDLE; a new 1-packet burst emits sequence 1.
